// File: rtl/uart_pkg.sv
// Frame constants shared between the TX packer and uart_controller.
package uart_pkg;

  localparam int FRAME_W = 40;

  localparam logic [7:0] HDR_ADS_DATA = 8'h41;
  localparam logic [7:0] HDR_MPR_DATA = 8'h4D;
  localparam logic [7:0] HDR_ADS_REG  = 8'h61;
  localparam logic [7:0] HDR_MPR_REG  = 8'h6D;

  // Slot indices double as o_OVERRUN bit positions; higher index wins arbitration.
  localparam int SRC_ADS = 0;
  localparam int SRC_MPR = 1;
  localparam int SRC_REG = 2;
  localparam int NUM_SRC = 3;

  function automatic logic [FRAME_W-1:0] fmt_short(input logic [7:0] hdr, input logic [15:0] payload);
    return {hdr, payload, 16'h0000};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with an occupancy counter; head reads 0 while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge i_CLK) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_packer.sv
// Formats ADS/MPR samples and register replies into 40-bit frames, holds one per
// source in a slot, and arbitrates them into a FWFT FIFO feeding the UART TX path.
module uart_tx_packer
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_STREAM_EN,
  input  logic [31:0]        i_ADS_DATA,
  input  logic               i_ADS_VALID,
  input  logic [15:0]        i_MPR_DATA,
  input  logic               i_MPR_VALID,
  input  logic               i_REG_SRC,
  input  logic [15:0]        i_REG_DATA,
  input  logic               i_REG_VALID,
  output logic [FRAME_W-1:0] o_UART_DATA_TX,
  output logic               o_UART_DATA_TX_VALID,
  input  logic               i_DATA_TX_READY,
  output logic [2:0]         o_OVERRUN,
  input  logic               i_OVERRUN_CLR
);

  logic [NUM_SRC-1:0] slot_stb, slot_pend, slot_move, ovr_set, slot_gated;
  logic [FRAME_W-1:0] new_frame  [NUM_SRC];
  logic [FRAME_W-1:0] slot_frame [NUM_SRC];
  logic [FRAME_W-1:0] push_frame;
  logic               stream_en_reg, stream_fall;
  logic [2:0]         overrun_reg;
  logic               fifo_empty, fifo_full, fifo_pop, fifo_push, can_write;

  assign slot_stb    = {i_REG_VALID, i_MPR_VALID && i_STREAM_EN, i_ADS_VALID && i_STREAM_EN};
  assign slot_gated  = 3'b011;
  assign stream_fall = stream_en_reg && !i_STREAM_EN;

  assign new_frame[SRC_ADS] = {HDR_ADS_DATA, i_ADS_DATA};
  assign new_frame[SRC_MPR] = fmt_short(HDR_MPR_DATA, i_MPR_DATA);
  assign new_frame[SRC_REG] = fmt_short(i_REG_SRC ? HDR_MPR_REG : HDR_ADS_REG, i_REG_DATA);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      logic               pend_reg;
      logic [FRAME_W-1:0] frame_reg;

      // A strobe coinciding with this slot's move refills it without counting as overrun.
      assign ovr_set[gi]    = slot_stb[gi] && pend_reg && !slot_move[gi];
      assign slot_pend[gi]  = pend_reg;
      assign slot_frame[gi] = frame_reg;

      always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
          pend_reg  <= 1'b0;
          frame_reg <= '0;
        end else if (slot_stb[gi]) begin
          pend_reg  <= 1'b1;
          frame_reg <= new_frame[gi];
        end else if (slot_move[gi] || (slot_gated[gi] && stream_fall)) begin
          pend_reg  <= 1'b0;
        end
      end
    end
  endgenerate

  assign fifo_pop  = !fifo_empty && i_DATA_TX_READY;
  assign can_write = !fifo_full || fifo_pop;

  always_comb begin
    slot_move = '0;
    if (can_write) begin
      if (slot_pend[SRC_REG])      slot_move[SRC_REG] = 1'b1;
      else if (slot_pend[SRC_MPR]) slot_move[SRC_MPR] = 1'b1;
      else if (slot_pend[SRC_ADS]) slot_move[SRC_ADS] = 1'b1;
    end
    push_frame = slot_move[SRC_REG] ? slot_frame[SRC_REG] :
                 slot_move[SRC_MPR] ? slot_frame[SRC_MPR] : slot_frame[SRC_ADS];
  end

  assign fifo_push = |slot_move;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      stream_en_reg <= 1'b0;
      overrun_reg   <= '0;
    end else begin
      stream_en_reg <= i_STREAM_EN;
      overrun_reg   <= (i_OVERRUN_CLR ? 3'b000 : overrun_reg) | ovr_set;
    end
  end

  assign o_OVERRUN = overrun_reg;

  sync_fifo_fwft #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_frame),
    .dout  (o_UART_DATA_TX),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign o_UART_DATA_TX_VALID = !fifo_empty;

endmodule
